// File: rtl/occupancy_pkg.sv
// Shared types and constants for the occupancy counter and its BCD converter.
package occupancy_pkg;

  localparam int MAX_CAPACITY = 99;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 (double dabble) converter: CW-bit binary to two BCD digits.
// One iteration per cycle; DONE accepts a new start so a stale result can be re-run at once.
module bin2bcd_seq
  import occupancy_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] bin,
  output bcd_t          tens,
  output bcd_t          ones,
  output logic          busy,
  output logic          done
);

  localparam int SW = CW + 8;
  localparam int IW = $clog2(CW + 1);

  conv_state_t   state, state_nxt;
  logic [SW-1:0] sr, sr_adj;
  logic [IW-1:0] iter;

  // Nibble correction ahead of the shift; tens never exceeds 9 for legal inputs.
  always_comb begin
    sr_adj = sr;
    if (sr[CW+3 -: 4] > 4'd4) sr_adj[CW+3 -: 4] = sr[CW+3 -: 4] + 4'd3;
    if (sr[CW+7 -: 4] > 4'd4) sr_adj[CW+7 -: 4] = sr[CW+7 -: 4] + 4'd3;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (iter == IW'(1)) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      sr    <= '0;
      iter  <= '0;
      tens  <= '0;
      ones  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE || state == DONE) && start) begin
        sr   <= {8'd0, bin};
        iter <= IW'(CW);
      end else if (state == SHIFT) begin
        sr   <= sr_adj << 1;
        iter <= iter - 1'b1;
      end
      if (state == DONE) begin
        tens <= sr[CW+7 -: 4];
        ones <= sr[CW+3 -: 4];
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/occupancy_counter.sv
// Saturating car-park occupancy counter with sticky over/underflow flags and a
// sequential BCD readout whose validity tracks the live count.
module occupancy_counter
  import occupancy_pkg::*;
#(
  parameter int CAPACITY = 15,
  parameter int CW       = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          entered,
  input  logic          exited,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow,
  output bcd_t          bcd_tens,
  output bcd_t          bcd_ones,
  output logic          bcd_valid
);

  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  logic          entered_q, exited_q;
  logic          ent_evt, ext_evt;
  logic [CW-1:0] count_prev;
  logic          chg, pending;
  logic          conv_start, conv_busy, conv_done;

  assign ent_evt = entered & ~entered_q;
  assign ext_evt = exited  & ~exited_q;
  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign chg     = (count != count_prev);
  // A finishing conversion restarts immediately if its input went stale meanwhile.
  assign conv_start = chg | (conv_done & pending);

  always_ff @(posedge clk) begin
    if (!reset) begin
      entered_q  <= 1'b1;
      exited_q   <= 1'b1;
      count      <= '0;
      count_prev <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      pending    <= 1'b0;
      bcd_valid  <= 1'b1;
    end else begin
      entered_q  <= entered;
      exited_q   <= exited;
      count_prev <= count;

      if (clear) begin
        count     <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else if (ent_evt && !ext_evt) begin
        if (full) overflow <= 1'b1;
        else      count    <= count + 1'b1;
      end else if (ext_evt && !ent_evt) begin
        if (empty) underflow <= 1'b1;
        else       count     <= count - 1'b1;
      end

      if (conv_done)             pending <= 1'b0;
      else if (chg && conv_busy) pending <= 1'b1;

      if (chg)                        bcd_valid <= 1'b0;
      else if (conv_done && !pending) bcd_valid <= 1'b1;
    end
  end

  bin2bcd_seq #(.CW(CW)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (count),
    .tens  (bcd_tens),
    .ones  (bcd_ones),
    .busy  (conv_busy),
    .done  (conv_done)
  );

endmodule

// File: doc/occupancy_counter.md
# occupancy_counter

Downstream consumer of the car-park entry/exit FSM. Turns that FSM's `entered`/`exited` outputs into a saturating occupancy count with full/empty status and sticky error flags. An iterative binary-to-BCD converter drives the two-digit display. It sits between the FSM and the seven-segment driver, in the same clock domain as the FSM.

## Interface
Parameters:
- `CAPACITY`, default 15: maximum occupancy; legal range 1..99.
- `CW`, default `$clog2(CAPACITY+1)`: count width; derived, never overridden.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `entered`  in  1  level from the FSM; each 0→1 transition is one entry event.
- `exited`  in  1  level from the FSM; each 0→1 transition is one exit event.
- `clear`  in  1  synchronous clear of the count and error flags.
- `count`  out  CW  current occupancy.
- `full`  out  1  `count == CAPACITY`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky; an entry was attempted while full.
- `underflow`  out  1  sticky; an exit was attempted while empty.
- `bcd_tens`  out  4  tens digit of the last completed conversion.
- `bcd_ones`  out  4  ones digit of the last completed conversion.
- `bcd_valid`  out  1  BCD digits match the current `count`.

## Operation
- Edge detect:
  - `ent_evt = entered & ~entered_q`; `ext_evt = exited & ~exited_q`.
  - `entered_q` and `exited_q` reset to 1, so inputs already high at reset release produce no event.
- Count update, in priority order per cycle:
  1. `clear`: count←0; overflow and underflow cleared. Any events in the same cycle are discarded.
  2. `ent_evt & ext_evt`: count unchanged; no flag set.
  3. `ent_evt`: if `full`, count is held and overflow←1; otherwise count+1.
  4. `ext_evt`: if `empty`, count is held and underflow←1; otherwise count−1.
- Count never wraps. All arithmetic is CW bits, unsigned.
- `full` and `empty` are combinational from the `count` register.
- BCD converter, a shift-add-3 state machine:
  - IDLE: on `start`, latch count, clear shift register, load iteration counter = CW, go to SHIFT.
  - SHIFT: one double-dabble iteration per cycle (add 3 to any nibble ≥5, then shift left 1). When the counter reaches 0, go to DONE.
  - DONE: write `bcd_tens`/`bcd_ones`, go to IDLE.
- `start` is raised for one cycle whenever `count` changed in the previous cycle (`count != count_prev`).
- A count change while the converter is in SHIFT/DONE sets `pending`. DONE then returns to SHIFT immediately with the new count, instead of going to IDLE.
- `bcd_valid`:
  - Cleared the cycle after any count change.
  - Set at DONE only if `pending` is 0.
  - Digits hold their old value until DONE.

## Timing
- Reset values:
  - count=0, empty=1, full=0, overflow=0, underflow=0.
  - bcd_tens=0, bcd_ones=0, bcd_valid=1.
  - converter in IDLE; `pending`=0; `count_prev`=0.
- Event latency:
  - An input rising edge sampled at edge k updates `count`, `full`, `empty` and the flags after edge k.
  - A level held high produces exactly one event.
- Conversion latency:
  - `bcd_valid` falls after edge k+1.
  - Digits are updated and `bcd_valid` rises after edge k+CW+2, i.e. 1 cycle IDLE→SHIFT, CW SHIFT cycles, 1 cycle DONE.
- Inputs are held at least 1 cycle high and 1 cycle low per event; the FSM guarantees this.
- Reset mid-conversion aborts the conversion and restores all reset values on the next edge.
- `clear` mid-conversion is a normal count change and sets `pending`.

## Structure
- Package `occupancy_pkg` holds:
  - the converter state enum `conv_state_t` {IDLE, SHIFT, DONE};
  - the `MAX_CAPACITY=99` constant;
  - the BCD digit typedef `bcd_t` (logic [3:0]).
- Sub-module `bin2bcd_seq`, parameterised by CW:
  - ports `clk`, `reset`, `start`, `bin`, `tens`, `ones`, `busy`, `done`;
  - `pending` logic stays in the parent.
- Parent: edge detect, counter, flags, `count_prev`, `bcd_valid`.

## Test plan
- Reset with `entered`=1 held, then 3 cycles → count=0, empty=1, no event, bcd_valid=1, digits 0/0.
- CAPACITY=3: 4 entry pulses → count 1,2,3,3; full=1 after 3rd; overflow=1 after 4th and stays set through 2 exits (count=1).
- CAPACITY=3: exit pulse at count 0 → underflow=1, count=0; then `clear` together with an entry edge → count=0, underflow=0.
- `entered` and `exited` rising on the same edge at count 2 → count stays 2, flags unchanged, bcd_valid stays 1.
- CAPACITY=15: 12 spaced entries → after the last, bcd_valid low for exactly CW+1=5 cycles, then tens=1, ones=2.
- CAPACITY=15: a second entry arriving 2 cycles into a conversion (count 9→10→11) → bcd_valid stays low until the restarted conversion ends; final digits 1/1, never transiently valid at 10.
